demux1_2_stream: RTL and testbench

Routes one input sample stream to one of two output channels: the receive-side counterpart of the 2:1 channel mux. Channel selection is sampled at the first beat of each frame and held until that frame's last beat. This keeps frames from being split across channels. Each output has a one-entry registered stage with valid/ready flow control, MSB-aligned width reduction and a per-channel frame counter. It sits between a shared acquisition or decode path and two per-channel processing chains.

---
 rtl/demux1_2_stream_if.sv | 38 +++
 rtl/demux1_2_stream.sv | 112 +++++++++++
 tb/tb_demux1_2_stream.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/demux1_2_stream_if.sv
// Stream bundle for the 1:2 frame demux: one upstream sample stream plus two
// downstream channel streams with their frame counters and busy flag.
interface demux1_2_stream_if #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int CNT_WIDTH    = 16
);
  logic                    Sel;
  logic [INPUT_WIDTH-1:0]  CH_IN;
  logic                    IN_VALID;
  logic                    IN_LAST;
  logic                    IN_READY;
  logic [OUTPUT_WIDTH-1:0] CH_OUT1;
  logic [OUTPUT_WIDTH-1:0] CH_OUT2;
  logic                    OUT_VALID1;
  logic                    OUT_VALID2;
  logic                    OUT_LAST1;
  logic                    OUT_LAST2;
  logic                    OUT_READY1;
  logic                    OUT_READY2;
  logic [CNT_WIDTH-1:0]    FRAME_CNT1;
  logic [CNT_WIDTH-1:0]    FRAME_CNT2;
  logic                    BUSY;

  // Upstream source and downstream sinks.
  modport master (
    output Sel, CH_IN, IN_VALID, IN_LAST, OUT_READY1, OUT_READY2,
    input  IN_READY, CH_OUT1, CH_OUT2, OUT_VALID1, OUT_VALID2,
    input  OUT_LAST1, OUT_LAST2, FRAME_CNT1, FRAME_CNT2, BUSY
  );

  // The demux itself.
  modport slave (
    input  Sel, CH_IN, IN_VALID, IN_LAST, OUT_READY1, OUT_READY2,
    output IN_READY, CH_OUT1, CH_OUT2, OUT_VALID1, OUT_VALID2,
    output OUT_LAST1, OUT_LAST2, FRAME_CNT1, FRAME_CNT2, BUSY
  );
endinterface

// File: rtl/demux1_2_stream.sv
// Routes whole frames of a sample stream to one of two registered output
// channels; the destination is locked on the first beat of each frame.
//
// state | meaning
// IDLE  | between frames, target follows Sel live
// ROUTE | mid-frame, target locked until the last beat is accepted
module demux1_2_stream #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk_in,
  input  logic                   RST_n,
  demux1_2_stream_if.slave       bus
);

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                  state;
  logic                    lock_sel;
  logic                    busy;
  logic                    valid1, valid2;
  logic                    last1, last2;
  logic [OUTPUT_WIDTH-1:0] data1, data2;
  logic [CNT_WIDTH-1:0]    cnt1, cnt2;

  logic                    target;
  logic                    in_ready;
  logic                    accept;
  logic                    drain1, drain2;
  logic [OUTPUT_WIDTH-1:0] sample;

  assign target   = (state == IDLE) ? bus.Sel : lock_sel;
  assign in_ready = RST_n && (target ? (!valid2 || bus.OUT_READY2)
                                     : (!valid1 || bus.OUT_READY1));
  assign accept   = bus.IN_VALID && in_ready;
  assign drain1   = valid1 && bus.OUT_READY1;
  assign drain2   = valid2 && bus.OUT_READY2;
  assign sample   = bus.CH_IN[INPUT_WIDTH-1 -: OUTPUT_WIDTH];

  always_ff @(posedge clk_in) begin
    if (!RST_n) begin
      state    <= IDLE;
      lock_sel <= 1'b0;
      busy     <= 1'b0;
      valid1   <= 1'b0;
      valid2   <= 1'b0;
      last1    <= 1'b0;
      last2    <= 1'b0;
      data1    <= '0;
      data2    <= '0;
      cnt1     <= '0;
      cnt2     <= '0;
    end else begin
      if (drain1) begin
        valid1 <= 1'b0;
        if (last1) cnt1 <= cnt1 + CNT_WIDTH'(1);
      end
      if (drain2) begin
        valid2 <= 1'b0;
        if (last2) cnt2 <= cnt2 + CNT_WIDTH'(1);
      end

      // A load in the same cycle as a drain overrides the valid clear above.
      if (accept) begin
        if (target) begin
          data2  <= sample;
          last2  <= bus.IN_LAST;
          valid2 <= 1'b1;
        end else begin
          data1  <= sample;
          last1  <= bus.IN_LAST;
          valid1 <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            lock_sel <= bus.Sel;
            if (!bus.IN_LAST) begin
              state <= ROUTE;
              busy  <= 1'b1;
            end
          end
        end
        ROUTE: begin
          if (accept && bus.IN_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IN_READY   = in_ready;
  assign bus.CH_OUT1    = data1;
  assign bus.CH_OUT2    = data2;
  assign bus.OUT_VALID1 = valid1;
  assign bus.OUT_VALID2 = valid2;
  assign bus.OUT_LAST1  = last1;
  assign bus.OUT_LAST2  = last2;
  assign bus.FRAME_CNT1 = cnt1;
  assign bus.FRAME_CNT2 = cnt2;
  assign bus.BUSY       = busy;

endmodule

// File: tb/tb_demux1_2_stream.sv
// Scoreboard bench: a full-width/16-bit-counter demux and an 8-bit/2-bit-counter
// demux share the same stimulus; a negedge monitor checks every output transfer.
module tb_demux1_2_stream;

  logic clk_in = 1'b0;
  logic RST_n;
  always #5 clk_in = ~clk_in;

  demux1_2_stream_if #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(12), .CNT_WIDTH(16)) bus_a ();
  demux1_2_stream_if #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(8),  .CNT_WIDTH(2))  bus_b ();

  demux1_2_stream #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(12), .CNT_WIDTH(16)) dut_a (
    .clk_in (clk_in),
    .RST_n  (RST_n),
    .bus    (bus_a.slave)
  );

  demux1_2_stream #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(8), .CNT_WIDTH(2)) dut_b (
    .clk_in (clk_in),
    .RST_n  (RST_n),
    .bus    (bus_b.slave)
  );

  assign bus_b.Sel        = bus_a.Sel;
  assign bus_b.CH_IN      = bus_a.CH_IN;
  assign bus_b.IN_VALID   = bus_a.IN_VALID;
  assign bus_b.IN_LAST    = bus_a.IN_LAST;
  assign bus_b.OUT_READY1 = bus_a.OUT_READY1;
  assign bus_b.OUT_READY2 = bus_a.OUT_READY2;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  always @(posedge clk_in) cyc++;

  // Scoreboard slots: 0/1 = wide ch1/ch2, 2/3 = narrow ch1/ch2; entry = {last, data}.
  logic [12:0] q [4][$];
  logic [3:0]  obs_v;
  logic [3:0]  obs_r;
  logic [12:0] obs [4];

  assign obs_v = {bus_b.OUT_VALID2, bus_b.OUT_VALID1, bus_a.OUT_VALID2, bus_a.OUT_VALID1};
  assign obs_r = {bus_a.OUT_READY2, bus_a.OUT_READY1, bus_a.OUT_READY2, bus_a.OUT_READY1};
  assign obs[0] = {bus_a.OUT_LAST1, bus_a.CH_OUT1};
  assign obs[1] = {bus_a.OUT_LAST2, bus_a.CH_OUT2};
  assign obs[2] = {bus_b.OUT_LAST1, 4'h0, bus_b.CH_OUT1};
  assign obs[3] = {bus_b.OUT_LAST2, 4'h0, bus_b.CH_OUT2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk_in) begin
    if (RST_n) begin
      for (int i = 0; i < 4; i++) begin
        if (obs_v[i] && obs_r[i]) begin
          if (q[i].size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat slot%0d: got 0x%0h, expected no beat", i, obs[i]);
          end else begin
            check($sformatf("beat slot%0d", i), 32'(obs[i]), 32'(q[i].pop_front()));
          end
        end
      end
    end
  end

  // ch: 0 = channel 1, 1 = channel 2 (hand-chosen destination of this beat).
  task automatic send(input logic [11:0] d, input logic last, input logic sel, input int ch);
    int n;
    q[ch].push_back({last, d});
    q[ch + 2].push_back({last, 4'h0, d[11:4]});
    bus_a.CH_IN    = d;
    bus_a.IN_LAST  = last;
    bus_a.Sel      = sel;
    bus_a.IN_VALID = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk_in);
      if (bus_a.IN_READY) break;
    end
    if (n == 20) begin
      checks++;
      $display("FAIL accept_timeout: beat 0x%0h not accepted, expected IN_READY=1", d);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus_a.IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 30; n++) begin
      @(posedge clk_in);
      #1;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) break;
    end
    if (n == 30) begin
      checks++;
      $display("FAIL drain_timeout: %0d beats still pending, expected 0",
               q[0].size() + q[1].size() + q[2].size() + q[3].size());
    end
  endtask

  task automatic check_cnts(input string tag, input int c1, input int c2);
    check({tag, " FRAME_CNT1"},   32'(bus_a.FRAME_CNT1), 32'(c1));
    check({tag, " FRAME_CNT2"},   32'(bus_a.FRAME_CNT2), 32'(c2));
    check({tag, " FRAME_CNT1_w"}, 32'(bus_b.FRAME_CNT1), 32'(c1 % 4));
    check({tag, " FRAME_CNT2_w"}, 32'(bus_b.FRAME_CNT2), 32'(c2 % 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    RST_n          = 1'b0;
    bus_a.Sel      = 1'b0;
    bus_a.CH_IN    = 12'h000;
    bus_a.IN_VALID = 1'b1;
    bus_a.IN_LAST  = 1'b0;
    bus_a.OUT_READY1 = 1'b1;
    bus_a.OUT_READY2 = 1'b1;

    // Reset state, with IN_READY forced low while reset is held.
    repeat (2) @(posedge clk_in);
    #1;
    check("rst IN_READY",   32'(bus_a.IN_READY), 0);
    check("rst OUT_VALID1", 32'(bus_a.OUT_VALID1), 0);
    check("rst OUT_VALID2", 32'(bus_a.OUT_VALID2), 0);
    check("rst CH_OUT1",    32'(bus_a.CH_OUT1), 0);
    check("rst OUT_LAST1",  32'(bus_a.OUT_LAST1), 0);
    check("rst BUSY",       32'(bus_a.BUSY), 0);
    check_cnts("rst", 0, 0);
    idle();
    RST_n = 1'b1;
    @(posedge clk_in);
    #1;

    // 4-beat frame to channel 1; first beat visible one cycle after acceptance.
    send(12'h123, 1'b0, 1'b0, 0);
    check("lat OUT_VALID1", 32'(bus_a.OUT_VALID1), 1);
    check("lat CH_OUT1",    32'(bus_a.CH_OUT1), 32'h123);
    check("lat CH_OUT1_w",  32'(bus_b.CH_OUT1), 32'h12);
    send(12'h456, 1'b0, 1'b0, 0);
    send(12'h789, 1'b0, 1'b0, 0);
    send(12'hABC, 1'b1, 1'b0, 0);
    idle();
    drain();
    check_cnts("frame1", 1, 0);

    // Channel 2 frame with Sel toggling each cycle after the first beat.
    send(12'h111, 1'b0, 1'b1, 1);
    check("route BUSY b1", 32'(bus_a.BUSY), 1);
    send(12'h222, 1'b0, 1'b0, 1);
    check("route BUSY b2", 32'(bus_a.BUSY), 1);
    send(12'h333, 1'b0, 1'b1, 1);
    check("route BUSY b3", 32'(bus_a.BUSY), 1);
    send(12'h444, 1'b1, 1'b0, 1);
    check("route BUSY end", 32'(bus_a.BUSY), 0);
    idle();
    drain();
    check_cnts("frame2", 1, 1);

    // Channel 1 backpressure for 3 cycles mid-frame.
    send(12'h0A1, 1'b0, 1'b0, 0);
    send(12'h0A2, 1'b0, 1'b1, 0);
    bus_a.OUT_READY1 = 1'b0;
    bus_a.CH_IN      = 12'h0A3;
    bus_a.IN_LAST    = 1'b0;
    bus_a.IN_VALID   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("stall IN_READY",   32'(bus_a.IN_READY), 0);
      check("stall OUT_VALID2", 32'(bus_a.OUT_VALID2), 0);
    end
    @(posedge clk_in);
    #1;
    bus_a.OUT_READY1 = 1'b1;
    send(12'h0A3, 1'b0, 1'b0, 0);
    send(12'h0A4, 1'b1, 1'b1, 0);
    idle();
    drain();
    check_cnts("stall", 2, 1);

    // Back-to-back single-beat frames alternating channels, one per cycle.
    t0 = cyc;
    send(12'hF01, 1'b1, 1'b0, 0);
    send(12'hF02, 1'b1, 1'b1, 1);
    send(12'hF03, 1'b1, 1'b0, 0);
    send(12'hF04, 1'b1, 1'b1, 1);
    send(12'hF05, 1'b1, 1'b0, 0);
    check("alt cycles", 32'(cyc - t0), 5);
    idle();
    drain();
    check_cnts("alt", 5, 3);

    // Reset during beat 2 with a beat still pending on channel 1.
    bus_a.OUT_READY1 = 1'b0;
    send(12'h501, 1'b0, 1'b0, 0);
    bus_a.CH_IN    = 12'h502;
    bus_a.IN_VALID = 1'b1;
    RST_n          = 1'b0;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 4; i++) q[i].delete();
    check("mid rst OUT_VALID1", 32'(bus_a.OUT_VALID1), 0);
    check("mid rst CH_OUT1",    32'(bus_a.CH_OUT1), 0);
    check("mid rst BUSY",       32'(bus_a.BUSY), 0);
    check_cnts("mid rst", 0, 0);
    RST_n = 1'b1;
    bus_a.OUT_READY1 = 1'b1;
    send(12'h777, 1'b0, 1'b1, 1);
    check("post rst BUSY", 32'(bus_a.BUSY), 1);
    send(12'h778, 1'b1, 1'b0, 1);
    idle();
    drain();
    check_cnts("post rst", 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
